// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/halt/step sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_e;

  localparam int unsigned DB_MAX_DEFAULT = 1_000_000;

  function automatic logic is_stopped(run_state_e s);
    return (s == ST_HALT) || (s == ST_BREAK);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-FF synchroniser, stability counter and press pulse on accepted 0->1.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DB_MAX   = DB_MAX_DEFAULT,
  parameter int unsigned DB_CNT_W = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic                sync_q1;
  logic                sync_q2;
  logic                level_q;
  logic [DB_CNT_W-1:0] cnt_q;
  logic                at_limit;

  assign at_limit = (cnt_q == DB_CNT_W'(DB_MAX - 1));

  // Fires in the cycle the accepted level is about to rise, so the consumer
  // acts on the same edge that accepts the new level.
  assign press = at_limit & sync_q2 & ~level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= button;
      sync_q2 <= sync_q1;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (at_limit) begin
        level_q <= sync_q2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer: drives the core's global advance enable, handles
// halt requests and PC breakpoints, and counts retired instructions.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DB_MAX   = DB_MAX_DEFAULT,
  parameter int unsigned DB_CNT_W = 20,
  parameter bit          BP_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button_run,
  input  logic        button_step,
  input  logic        halt_req,
  input  logic [31:0] pc,
  input  logic        bp_valid,
  input  logic [31:0] bp_addr,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic        step_done,
  output logic [31:0] retired_cnt
);

  run_state_e  state_q;
  logic        resume_q;
  logic        step_done_q;
  logic        halted_q;
  logic [31:0] retired_q;

  logic run_p;
  logic step_p;
  logic bp_hit;
  logic stop_run;

  btn_debounce #(
    .DB_MAX   (DB_MAX),
    .DB_CNT_W (DB_CNT_W)
  ) u_db_run (
    .clk    (clk),
    .reset  (reset),
    .button (button_run),
    .press  (run_p)
  );

  btn_debounce #(
    .DB_MAX   (DB_MAX),
    .DB_CNT_W (DB_CNT_W)
  ) u_db_step (
    .clk    (clk),
    .reset  (reset),
    .button (button_step),
    .press  (step_p)
  );

  assign bp_hit   = BP_EN & bp_valid & (pc == bp_addr);
  // resume lets the instruction sitting on the breakpoint commit once
  assign stop_run = halt_req | (bp_hit & ~resume_q);

  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN:  cpu_en = ~stop_run;
      ST_STEP: cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
    // Nothing may commit in a reset cycle
    if (reset) begin
      cpu_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HALT;
      resume_q    <= 1'b0;
      step_done_q <= 1'b0;
      halted_q    <= 1'b1;
      retired_q   <= '0;
    end else begin
      step_done_q <= (state_q == ST_STEP);
      if (cpu_en) begin
        retired_q <= retired_q + 32'd1;
      end
      case (state_q)
        ST_HALT: begin
          if (run_p) begin
            state_q  <= ST_RUN;
            halted_q <= is_stopped(ST_RUN);
          end else if (step_p) begin
            state_q  <= ST_STEP;
            halted_q <= is_stopped(ST_STEP);
          end
        end
        ST_RUN: begin
          resume_q <= 1'b0;
          if (run_p) begin
            state_q  <= ST_HALT;
            halted_q <= is_stopped(ST_HALT);
          end else if (stop_run) begin
            state_q  <= ST_BREAK;
            halted_q <= is_stopped(ST_BREAK);
          end
        end
        ST_STEP: begin
          state_q  <= ST_HALT;
          halted_q <= is_stopped(ST_HALT);
        end
        ST_BREAK: begin
          if (run_p) begin
            state_q  <= ST_RUN;
            resume_q <= 1'b1;
            halted_q <= is_stopped(ST_RUN);
          end else if (step_p) begin
            state_q  <= ST_STEP;
            halted_q <= is_stopped(ST_STEP);
          end
        end
        default: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign halted      = halted_q;
  assign step_done   = step_done_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: directed scenarios then randomized button/halt/bp traffic.
module tb_cpu_run_ctrl;

  localparam int unsigned DB_MAX   = 4;
  localparam int unsigned DB_CNT_W = 3;

  localparam int M_HALT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_BREAK = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        button_run;
  logic        button_step;
  logic        halt_req;
  logic [31:0] pc;
  logic        bp_valid;
  logic [31:0] bp_addr;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic        step_done;
  logic [31:0] retired_cnt;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DB_MAX   (DB_MAX),
    .DB_CNT_W (DB_CNT_W),
    .BP_EN    (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_run  (button_run),
    .button_step (button_step),
    .halt_req    (halt_req),
    .pc          (pc),
    .bp_valid    (bp_valid),
    .bp_addr     (bp_addr),
    .cpu_en      (cpu_en),
    .state       (state),
    .halted      (halted),
    .step_done   (step_done),
    .retired_cnt (retired_cnt)
  );

  typedef struct packed {
    int          cyc;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic        step_done;
    logic [31:0] retired;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model
  int          m_mode;
  bit          m_resume;
  bit          m_step_done;
  bit          m_valid = 1'b0;
  logic [31:0] m_retired;
  int          cyc = 0;
  int          run_hi = 0;
  int          step_hi = 0;
  bit          run_sched[int];
  bit          step_sched[int];

  function automatic void chk(input string name, input int at, input logic [31:0] act,
                              input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 25) begin
        $display("FAIL %s cycle %0d: got %h expected %h", name, at, act, expv);
      end
    end
  endfunction

  // A clean press held DB_MAX cycles takes effect on the edge 2+DB_MAX after it started,
  // i.e. 3 edges after its DB_MAX-th high cycle.
  task automatic tick();
    bit   run_p, step_p, bp, stop, en;
    exp_t e;
    if (reset) begin
      run_hi  = 0;
      step_hi = 0;
      run_sched.delete();
      step_sched.delete();
    end else begin
      run_hi  = button_run  ? run_hi + 1  : 0;
      step_hi = button_step ? step_hi + 1 : 0;
      if (run_hi == int'(DB_MAX))  run_sched[cyc + 3] = 1'b1;
      if (step_hi == int'(DB_MAX)) step_sched[cyc + 3] = 1'b1;
    end
    run_p  = run_sched.exists(cyc + 1);
    step_p = step_sched.exists(cyc + 1);
    bp     = bp_valid && (pc == bp_addr);
    stop   = halt_req || (bp && !m_resume);
    if (m_mode == M_RUN)       en = !stop;
    else if (m_mode == M_STEP) en = 1'b1;
    else                       en = 1'b0;
    if (reset) en = 1'b0;

    if (m_valid) begin
      e.cyc       = cyc;
      e.cpu_en    = en;
      e.state     = 2'(m_mode);
      e.halted    = (m_mode == M_HALT) || (m_mode == M_BREAK);
      e.step_done = m_step_done;
      e.retired   = m_retired;
      sb_q.push_back(e);
    end

    if (reset) begin
      m_mode      = M_HALT;
      m_resume    = 1'b0;
      m_step_done = 1'b0;
      m_retired   = 32'd0;
      m_valid     = 1'b1;
    end else begin
      if (en) m_retired = m_retired + 32'd1;
      m_step_done = (m_mode == M_STEP);
      if (m_mode == M_HALT) begin
        if (run_p)       m_mode = M_RUN;
        else if (step_p) m_mode = M_STEP;
      end else if (m_mode == M_RUN) begin
        m_resume = 1'b0;
        if (run_p)     m_mode = M_HALT;
        else if (stop) m_mode = M_BREAK;
      end else if (m_mode == M_STEP) begin
        m_mode = M_HALT;
      end else begin
        if (run_p) begin
          m_mode   = M_RUN;
          m_resume = 1'b1;
        end else if (step_p) begin
          m_mode = M_STEP;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    if (en) pc = pc + 32'd4;
  endtask

  task automatic press(input bit r, input bit s, input int len, input int gap);
    button_run  = r;
    button_step = s;
    repeat (len) tick();
    button_run  = 1'b0;
    button_step = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    a        = 32'd0;
    a[5:2]   = 4'($urandom_range(0, 15));
    a[31]    = ($urandom_range(0, 3) == 0);
    return a;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("cpu_en",      e.cyc, {31'd0, cpu_en},    {31'd0, e.cpu_en});
      chk("state",       e.cyc, {30'd0, state},     {30'd0, e.state});
      chk("halted",      e.cyc, {31'd0, halted},    {31'd0, e.halted});
      chk("step_done",   e.cyc, {31'd0, step_done}, {31'd0, e.step_done});
      chk("retired_cnt", e.cyc, retired_cnt,        e.retired);
    end
  end

  initial begin
    int run_left, run_cool, step_left, step_cool;
    reset       = 1'b1;
    button_run  = 1'b0;
    button_step = 1'b0;
    halt_req    = 1'b0;
    pc          = 32'd0;
    bp_valid    = 1'b0;
    bp_addr     = 32'd0;
    @(posedge clk);
    #1;
    repeat (3) tick();
    reset = 1'b0;

    press(1'b1, 1'b0, 3, 12);   // glitch: no pulse
    press(1'b0, 1'b1, 6, 14);   // single step from HALT
    press(1'b1, 1'b0, 10, 6);   // clean run press
    press(1'b1, 1'b0, 6, 14);   // back to HALT

    // Breakpoint at 0x10 from a fresh reset
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    pc       = 32'd0;
    bp_valid = 1'b1;
    bp_addr  = 32'h0000_0010;
    press(1'b1, 1'b0, 6, 14);
    press(1'b1, 1'b0, 6, 4);    // resume past the breakpoint
    bp_valid = 1'b0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    repeat (3) tick();
    press(1'b0, 1'b1, 6, 12);   // step out of BREAK
    press(1'b1, 1'b1, 6, 6);    // simultaneous: run wins

    reset = 1'b1;               // reset while running
    tick();
    reset = 1'b0;
    repeat (2) tick();

    force dut.retired_q = 32'hFFFF_FFFF;
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    press(1'b0, 1'b1, 6, 10);   // one commit wraps the counter

    run_left  = 0;
    run_cool  = 0;
    step_left = 0;
    step_cool = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = 1'b0;
      if (run_left == 0 && run_cool == 0 && step_left == 0 && step_cool == 0 &&
          $urandom_range(0, 399) == 0) begin
        reset = 1'b1;
      end else if (run_left == 0 && run_cool == 0 && step_left == 0 && step_cool == 0 &&
                   $urandom_range(0, 59) == 0) begin
        button_run  = 1'b1;
        button_step = 1'b1;
        run_left    = $urandom_range(1, 10);
        step_left   = run_left;
      end else begin
        if (run_left > 0) begin
          run_left--;
          if (run_left == 0) begin
            button_run = 1'b0;
            run_cool   = int'(DB_MAX) + $urandom_range(0, 6);
          end
        end else if (run_cool > 0) begin
          run_cool--;
        end else if ($urandom_range(0, 24) == 0) begin
          button_run = 1'b1;
          run_left   = $urandom_range(1, 10);
        end
        if (step_left > 0) begin
          step_left--;
          if (step_left == 0) begin
            button_step = 1'b0;
            step_cool   = int'(DB_MAX) + $urandom_range(0, 6);
          end
        end else if (step_cool > 0) begin
          step_cool--;
        end else if ($urandom_range(0, 24) == 0) begin
          button_step = 1'b1;
          step_left   = $urandom_range(1, 10);
        end
      end
      halt_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) bp_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bp_addr = pick_addr();
      if ($urandom_range(0, 31) == 0) pc = pick_addr();
      tick();
    end

    reset       = 1'b0;
    button_run  = 1'b0;
    button_step = 1'b0;
    halt_req    = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      chk("scoreboard_drain", cyc, sb_q.size(), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
